// File: rtl/math_addsub_pipe.sv
// math_addsub_pipe -- pipelined signed adder/subtractor with a segmented carry chain.
//
// The operands are split into NSEG = LATENCY+1 segments, LSB first. Segment k
// is one bit wider than floor(WIDTH/NSEG) when k < WIDTH mod NSEG. Segment 0
// is summed in the input cycle. Each later segment is summed one register
// stage after the previous one, and takes the registered carry as its
// carry-in. Operands travel up the pipeline beside the partial result, so
// every segment of a sample lines up at the output.
//
// Optional feature: define MATH_ADDSUB_SAT_EN to clamp dout on signed
// overflow. With the macro undefined, dout wraps modulo 2^WIDTH. Both builds
// have the same latency.
//
// Parameters:
//   WIDTH   operand/result width, 2..64
//   LATENCY register stages from input to output, 0..WIDTH-1
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every register, overrides ena
//   ena        pipeline advance; low holds every register
//   vin        input operands valid
//   sub        0: dina+dinb, 1: dina-dinb (travels with its operands)
//   dina/dinb  signed operands
//   dout       signed result, combinational from the final segment
//   vout       dout valid
//   ovf        signed overflow of dout, qualified by vout
module math_addsub_pipe #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             vin,
  input  logic             sub,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  output logic [WIDTH-1:0] dout,
  output logic             vout,
  output logic             ovf
);

  localparam int NSEG = LATENCY + 1;
  localparam int BASE = WIDTH / NSEG;
  localparam int REM  = WIDTH % NSEG;

  // Stage s holds full-width operands, the sub flag, the carry into segment s
  // and the partial result (segments below s already filled in). Bits that a
  // stage no longer needs are left in place and trimmed by synthesis.
  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    localparam int SW = BASE + ((s < REM) ? 1 : 0);
    localparam int LO = s * BASE + ((s < REM) ? s : REM);
    localparam int HI = LO + SW - 1;

    logic [WIDTH-1:0] a, b, r_in, r_out;
    logic             sb, ci, co;
    logic [SW:0]      sum;

    if (s == 0) begin : g_in
      // Subtract is a + ~b + 1. The +1 enters as the carry-in of segment 0.
      assign a    = dina;
      assign b    = dinb;
      assign sb   = sub;
      assign ci   = sub;
      assign r_in = '0;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          a    <= '0;
          b    <= '0;
          sb   <= 1'b0;
          ci   <= 1'b0;
          r_in <= '0;
        end else if (ena) begin
          a    <= g_seg[s-1].a;
          b    <= g_seg[s-1].b;
          sb   <= g_seg[s-1].sb;
          ci   <= g_seg[s-1].co;
          r_in <= g_seg[s-1].r_out;
        end
      end
    end

    assign sum = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO] ^ {SW{sb}}} + {{SW{1'b0}}, ci};
    assign co  = sum[SW];

    always_comb begin
      r_out        = r_in;
      r_out[HI:LO] = sum[SW-1:0];
    end

    if (s == NSEG - 1) begin : g_last
      // The last stage reads only its own operand slice and ignores the
      // incoming copy of its own result slice.
      logic unused_last;
      assign unused_last = ^{a, b, r_in};
    end
  end

  // Valid travels in a shift register beside the data. Entry 0 is the live input.
  logic [LATENCY:0] vld_pipe;
  assign vld_pipe[0] = vin;

  if (LATENCY > 0) begin : g_vld
    always_ff @(posedge clk) begin
      if (rst)      vld_pipe[LATENCY:1] <= '0;
      else if (ena) vld_pipe[LATENCY:1] <= vld_pipe[LATENCY-1:0];
    end
  end

  assign vout = vld_pipe[LATENCY];

  // Overflow is the carry into the MSB XOR the carry out of the MSB. The
  // carry into the MSB comes back out of the MSB sum bit: a ^ b' ^ s.
  logic [WIDTH-1:0] raw;
  logic             b_msb, c_msb;

  assign raw   = g_seg[LATENCY].r_out;
  assign b_msb = g_seg[LATENCY].b[WIDTH-1] ^ g_seg[LATENCY].sb;
  assign c_msb = g_seg[LATENCY].a[WIDTH-1] ^ b_msb ^ raw[WIDTH-1];
  assign ovf   = c_msb ^ g_seg[LATENCY].co;

`ifdef MATH_ADDSUB_SAT_EN
  // A wrapped result has the wrong sign. A negative-looking raw result
  // therefore means positive overflow, and the output clamps to the
  // opposite extreme of the raw sign.
  assign dout = ovf ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
  assign dout = raw;
`endif

endmodule

// File: tb/tb_math_addsub_pipe.sv
// Directed bench for math_addsub_pipe. Four instances cover the widths and
// latencies of interest. They share the control inputs, and each test
// observes only the instance it targets.
module tb_math_addsub_pipe;

`ifdef MATH_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, vin, sub;
  logic [15:0] a16, b16, d_l1, d_l3;
  logic [12:0] a13, b13, d_l13;
  logic [7:0]  a8, b8, d_l0;
  logic        v_l1, o_l1, v_l3, o_l3, v_l13, o_l13, v_l0, o_l0;

  math_addsub_pipe #(.WIDTH(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .ena(ena), .vin(vin), .sub(sub),
    .dina(a16), .dinb(b16), .dout(d_l1), .vout(v_l1), .ovf(o_l1));

  math_addsub_pipe #(.WIDTH(16), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .ena(ena), .vin(vin), .sub(sub),
    .dina(a16), .dinb(b16), .dout(d_l3), .vout(v_l3), .ovf(o_l3));

  math_addsub_pipe #(.WIDTH(13), .LATENCY(2)) u_l13 (
    .clk(clk), .rst(rst), .ena(ena), .vin(vin), .sub(sub),
    .dina(a13), .dinb(b13), .dout(d_l13), .vout(v_l13), .ovf(o_l13));

  math_addsub_pipe #(.WIDTH(8), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .ena(ena), .vin(vin), .sub(sub),
    .dina(a8), .dinb(b8), .dout(d_l0), .vout(v_l0), .ovf(o_l0));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic flush;
    ena = 1'b1; vin = 1'b0; sub = 1'b0;
    a16 = '0; b16 = '0; a13 = '0; b13 = '0;
    repeat (5) step;
  endtask

  // 13-bit vectors (segments 5/4/4) with hand-computed results.
  logic [12:0] va [6], vb [6], xd [6];
  logic        vs [6], xo [6];

  initial begin
    va = '{13'h0FFF, 13'h001F, 13'h01FF, 13'h0000, 13'h1000, 13'h1555};
    vb = '{13'h0001, 13'h0001, 13'h0001, 13'h0001, 13'h0001, 13'h0AAA};
    vs = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    xd = '{SAT ? 13'h0FFF : 13'h1000, 13'h0020, 13'h0200, 13'h1FFF,
           SAT ? 13'h1000 : 13'h0FFF, 13'h1FFF};
    xo = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; ena = 1'b0; vin = 1'b0; sub = 1'b0;
    a16 = '0; b16 = '0; a13 = '0; b13 = '0; a8 = '0; b8 = '0;
    step; step;
    rst = 1'b0;
    chk("rst_l1_vout", v_l1, 0);
    chk("rst_l1_dout", d_l1, 0);
    chk("rst_l1_ovf",  o_l1, 0);
    chk("rst_l3_vout", v_l3, 0);
    chk("rst_l3_dout", d_l3, 0);

    // Back-to-back samples: carry across a segment, +overflow, -overflow.
    ena = 1'b1; vin = 1'b1; sub = 1'b0; a16 = 16'h00FF; b16 = 16'h0001;
    step;
    chk("l1_s0_vout", v_l1, 1);
    chk("l1_s0_dout", d_l1, 16'h0100);
    chk("l1_s0_ovf",  o_l1, 0);
    sub = 1'b0; a16 = 16'h7FFF; b16 = 16'h0001;
    step;
    chk("l1_s1_dout", d_l1, SAT ? 16'h7FFF : 16'h8000);
    chk("l1_s1_ovf",  o_l1, 1);
    chk("l3_s1_vout_early", v_l3, 0);
    sub = 1'b1; a16 = 16'h8000; b16 = 16'h0001;
    step;
    chk("l1_s2_dout", d_l1, SAT ? 16'h8000 : 16'h7FFF);
    chk("l1_s2_ovf",  o_l1, 1);
    chk("l3_s0_vout", v_l3, 1);
    chk("l3_s0_dout", d_l3, 16'h0100);
    chk("l3_s0_ovf",  o_l3, 0);
    vin = 1'b0; sub = 1'b0; a16 = '0; b16 = '0;
    step;
    chk("l1_drain_vout", v_l1, 0);
    chk("l3_s1_vout", v_l3, 1);
    chk("l3_s1_dout", d_l3, SAT ? 16'h7FFF : 16'h8000);
    chk("l3_s1_ovf",  o_l3, 1);
    step;
    chk("l3_s2_vout", v_l3, 1);
    chk("l3_s2_dout", d_l3, SAT ? 16'h8000 : 16'h7FFF);
    chk("l3_s2_ovf",  o_l3, 1);
    step;
    chk("l3_drain_vout", v_l3, 0);

    // LATENCY=0 is purely combinational.
    vin = 1'b1; sub = 1'b1; a8 = 8'h80; b8 = 8'h01;
    #1;
    chk("l0_neg_vout", v_l0, 1);
    chk("l0_neg_dout", d_l0, SAT ? 8'h80 : 8'h7F);
    chk("l0_neg_ovf",  o_l0, 1);
    sub = 1'b0; a8 = 8'h7F; b8 = 8'h01;
    #1;
    chk("l0_pos_dout", d_l0, SAT ? 8'h7F : 8'h80);
    chk("l0_pos_ovf",  o_l0, 1);
    sub = 1'b1; a8 = 8'h05; b8 = 8'h07;
    #1;
    chk("l0_sub_dout", d_l0, 8'hFE);
    chk("l0_sub_ovf",  o_l0, 0);
    vin = 1'b0;
    #1;
    chk("l0_vout_low", v_l0, 0);

    // 13-bit stream under an irregular ena pattern; in order, no losses.
    flush;
    begin
      int ii = 0;
      int io = 0;
      bit e;
      for (int c = 0; c < 100 && io < 6; c++) begin
        e   = ($urandom_range(0, 1) == 1);
        ena = e;
        vin = (ii < 6);
        if (ii < 6) begin
          a13 = va[ii]; b13 = vb[ii]; sub = vs[ii];
        end else begin
          a13 = '0; b13 = '0; sub = 1'b0;
        end
        step;
        if (e && ii < 6) ii++;
        // Only an ena edge presents a new output; a held output is not a new sample.
        if (e && v_l13) begin
          chk($sformatf("l13_v%0d_dout", io), d_l13, xd[io]);
          chk($sformatf("l13_v%0d_ovf",  io), o_l13, xo[io]);
          io++;
        end
      end
      chk("l13_count", io, 6);
    end

    // Stall the pipeline at every position a sample passes through.
    flush;
    ena = 1'b0; vin = 1'b1; sub = 1'b0; a16 = 16'h0FFF; b16 = 16'h0001;
    repeat (5) begin
      step;
      chk("stall_p0_vout", v_l3, 0);
    end
    ena = 1'b1;
    step;
    vin = 1'b0; a16 = '0; b16 = '0;
    for (int p = 1; p < 3; p++) begin
      ena = 1'b0;
      repeat (5) begin
        step;
        chk($sformatf("stall_p%0d_vout", p), v_l3, 0);
      end
      ena = 1'b1;
      step;
    end
    chk("stall_out_vout", v_l3, 1);
    chk("stall_out_dout", d_l3, 16'h1000);
    chk("stall_out_ovf",  o_l3, 0);
    ena = 1'b0;
    repeat (5) begin
      step;
      chk("stall_hold_vout", v_l3, 1);
      chk("stall_hold_dout", d_l3, 16'h1000);
    end
    ena = 1'b1;
    step;
    chk("stall_after_vout", v_l3, 0);

    // Reset with samples in flight and ena low; nothing stale may emerge.
    ena = 1'b1; vin = 1'b1; sub = 1'b0; a16 = 16'h1111; b16 = 16'h2222;
    step;
    a16 = 16'h3333;
    step;
    rst = 1'b1; ena = 1'b0;
    step;
    rst = 1'b0;
    chk("mrst_l3_vout", v_l3, 0);
    chk("mrst_l3_dout", d_l3, 0);
    chk("mrst_l3_ovf",  o_l3, 0);
    chk("mrst_l1_vout", v_l1, 0);
    chk("mrst_l1_dout", d_l1, 0);
    vin = 1'b0; a16 = '0; b16 = '0; ena = 1'b1;
    repeat (4) begin
      step;
      chk("mrst_drain_vout", v_l3, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
